// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. Produces H/V and
//                composite sync, the active-video flag, pixel coordinates,
//                and line/frame start pulses. The coordinates run LEAD pixel
//                ticks ahead of the timing flags, so a frame-buffer read
//                issued from X/Y has LEAD ticks to return its pixel before
//                the DAC samples it alongside the matching flags.
//  Revision    : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    CLK_VGA      in   1   pixel clock
//    RST_N        in   1   active-low reset (asserts asynchronously; its
//                          release must already be synchronous to CLK_VGA)
//    EN           in   1   run enable; low holds the raster at the origin
//    CE           in   1   pixel tick qualifier; raster advances on EN & CE
//    SYNC_H       out  1   horizontal sync, active level HPOL
//    SYNC_V       out  1   vertical sync, active level VPOL
//    SYNC_B       out  1   composite sync, active-low
//    SYNC_BLANK   out  1   1 = active video
//    X            out  CW  horizontal pixel counter
//    Y            out  CW  vertical line counter
//    LINE_START   out  1   one-clock pulse on the tick at X == 0
//    FRAME_START  out  1   one-clock pulse on the tick at X == 0, Y == 0
//    FRAME_CNT    out  8   completed frames, modulo 256
// ============================================================================
module vga_timing_gen #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYN    = 2,
    parameter int VBP     = 33,
    parameter bit HPOL    = 1'b0,
    parameter bit VPOL    = 1'b0,
    parameter int CW      = 11,
    parameter int LEAD    = 1
) (
    input  logic          CLK_VGA,
    input  logic          RST_N,
    input  logic          EN,
    input  logic          CE,
    output logic          SYNC_H,
    output logic          SYNC_V,
    output logic          SYNC_B,
    output logic          SYNC_BLANK,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          LINE_START,
    output logic          FRAME_START,
    output logic [7:0]    FRAME_CNT
);

    // ------------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------------
    localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

    // Region bounds are held one bit wider than the counters: a sync pulse
    // that ends exactly at HTOTAL == 2**CW would otherwise wrap to zero.
    localparam logic [CW:0] c_hactive = (CW+1)'(HACTIVE);
    localparam logic [CW:0] c_hs_beg  = (CW+1)'(HACTIVE + HFP);
    localparam logic [CW:0] c_hs_end  = (CW+1)'(HACTIVE + HFP + HSYN);
    localparam logic [CW:0] c_vactive = (CW+1)'(VACTIVE);
    localparam logic [CW:0] c_vs_beg  = (CW+1)'(VACTIVE + VFP);
    localparam logic [CW:0] c_vs_end  = (CW+1)'(VACTIVE + VFP + VSYN);

    localparam logic [CW-1:0] c_h_last = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] c_v_last = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] c_one    = CW'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if ((LEAD < 1) || (LEAD > 7)) begin : g_bad_lead
        $error("vga_timing_gen: LEAD=%0d outside legal range 1..7", LEAD);
    end

    if (HTOTAL > (1 << CW)) begin : g_bad_htotal
        $error("vga_timing_gen: HTOTAL=%0d does not fit in CW=%0d bits", HTOTAL, CW);
    end

    if (VTOTAL > (1 << CW)) begin : g_bad_vtotal
        $error("vga_timing_gen: VTOTAL=%0d does not fit in CW=%0d bits", VTOTAL, CW);
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0]   h_q,      h_d;
    logic [CW-1:0]   v_q,      v_d;
    logic [7:0]      fcnt_q,   fcnt_d;

    // Flag delay lines; index 0 is the newest stage, LEAD-1 drives the pins.
    logic [LEAD-1:0] hs_dl_q,  hs_dl_d;
    logic [LEAD-1:0] vs_dl_q,  vs_dl_d;
    logic [LEAD-1:0] de_dl_q,  de_dl_d;

    // ------------------------------------------------------------------------
    // Decode of the current raster position
    // ------------------------------------------------------------------------
    logic [CW:0] w_h_ext;
    logic [CW:0] w_v_ext;
    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_de;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_tick;

    assign w_h_ext  = {1'b0, h_q};
    assign w_v_ext  = {1'b0, v_q};

    assign w_hs_act = (w_h_ext >= c_hs_beg) && (w_h_ext < c_hs_end);
    assign w_vs_act = (w_v_ext >= c_vs_beg) && (w_v_ext < c_vs_end);
    assign w_de     = (w_h_ext < c_hactive) && (w_v_ext < c_vactive);

    assign w_h_last = (h_q == c_h_last);
    assign w_v_last = (v_q == c_v_last);
    assign w_tick   = EN & CE;

    // ------------------------------------------------------------------------
    // Raster counters and frame counter
    // ------------------------------------------------------------------------
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        fcnt_d = fcnt_q;

        if (!EN) begin
            // Park at the origin so the first tick after EN returns starts a
            // fresh frame; the frame count is deliberately left alone.
            h_d = '0;
            v_d = '0;
        end else if (CE) begin
            if (w_h_last) begin
                h_d = '0;
                if (w_v_last) begin
                    v_d    = '0;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    v_d = v_q + c_one;
                end
            end else begin
                h_d = h_q + c_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flag delay lines
    // ------------------------------------------------------------------------
    // The lines shift on CE alone (not EN), so after EN drops they drain to
    // the inactive level within LEAD ticks instead of freezing mid-pulse.
    always_comb begin
        hs_dl_d = hs_dl_q;
        vs_dl_d = vs_dl_q;
        de_dl_d = de_dl_q;

        if (CE) begin
            hs_dl_d[0] = EN & w_hs_act;
            vs_dl_d[0] = EN & w_vs_act;
            de_dl_d[0] = EN & w_de;
            for (int i = 1; i < LEAD; i++) begin
                hs_dl_d[i] = hs_dl_q[i-1];
                vs_dl_d[i] = vs_dl_q[i-1];
                de_dl_d[i] = de_dl_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            h_q     <= '0;
            v_q     <= '0;
            fcnt_q  <= '0;
            hs_dl_q <= '0;
            vs_dl_q <= '0;
            de_dl_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            fcnt_q  <= fcnt_d;
            hs_dl_q <= hs_dl_d;
            vs_dl_q <= vs_dl_d;
            de_dl_q <= de_dl_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Sync pins come straight from the final delay stage; polarity is a
    // constant mapping, so EN/CE have no combinational route to them.
    assign SYNC_H     = hs_dl_q[LEAD-1] ? HPOL : ~HPOL;
    assign SYNC_V     = vs_dl_q[LEAD-1] ? VPOL : ~VPOL;
    assign SYNC_B     = ~(hs_dl_q[LEAD-1] | vs_dl_q[LEAD-1]);
    assign SYNC_BLANK = de_dl_q[LEAD-1];

    assign X          = h_q;
    assign Y          = v_q;
    assign FRAME_CNT  = fcnt_q;

    // Qualified by the tick so each pulse spans exactly one clock, even when
    // CE is sparse and the counters sit at the origin for several clocks.
    assign LINE_START  = w_tick & (h_q == '0);
    assign FRAME_START = w_tick & (h_q == '0) & (v_q == '0);

endmodule
`default_nettype wire
